seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional build macro DIVZERO_DETECT_EN: zero-divisor short-circuit with div_by_zero flag.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int RW = WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [RW-1:0]    r_reg;
   logic [CW-1:0]    cnt;

   logic [RW:0]      r_wide;
   logic             ge;
   logic [RW-1:0]    r_next;
   logic [WIDTH-1:0] q_next;
   logic             last;

   // One restoring step: shift {R,Q} left, trial-subtract the divisor.
   always_comb begin
      r_wide = {r_reg, q_reg[WIDTH-1]};
      ge     = (r_wide >= {2'b00, d_reg});
      r_next = ge ? RW'(r_wide - {2'b00, d_reg}) : RW'(r_wide);
      q_next = {q_reg[WIDTH-2:0], ge};
      last   = (cnt == CW'(WIDTH - 1));
   end

`ifdef DIVZERO_DETECT_EN
   logic dbz_q;
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         r_reg     <= '0;
         cnt       <= '0;
`ifdef DIVZERO_DETECT_EN
         dbz_q     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  r_reg <= '0;
                  cnt   <= '0;
`ifdef DIVZERO_DETECT_EN
                  dbz_q <= 1'b0;
                  if (divisor == '0) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                     dbz_q     <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
`else
                  state <= RUN;
                  busy  <= 1'b1;
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               cnt   <= cnt + 1'b1;
               // Result registers load only here so they stay stable while iterating.
               if (last) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_next;
                  remainder <= r_next[WIDTH-1:0];
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

   localparam int W = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

`ifdef DIVZERO_DETECT_EN
   localparam int ZLAT = 1;
   localparam int ZFLAG = 1;
`else
   localparam int ZLAT = W + 1;
   localparam int ZFLAG = 0;
`endif

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic int ref_q(input int a, input int b);
      return (b == 0) ? MAXV : a / b;
   endfunction

   function automatic int ref_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   // One isolated operation from idle; lat counts cycles from accepting edge to done.
   task automatic op(input int a, input int b, output int lat, output int busy_n,
                     output int q, output int r, output int z);
      lat = -1; busy_n = 0; q = -1; r = -1; z = -1;
      @(negedge clk);
      dividend = W'(a); divisor = W'(b); start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", busy, done);
         end
         if (done) begin
            lat = j + 1; q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
            break;
         end
         if (busy) busy_n++;
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_single_pulse: done=%0b required 0", done);
      end
   endtask

   task automatic check_op(input string name, input int a, input int b);
      int lat, bn, q, r, z, elat;
      elat = (b == 0) ? ZLAT : W + 1;
      op(a, b, lat, bn, q, r, z);
      checks++;
      if (lat !== elat || q !== ref_q(a, b) || r !== ref_r(a, b) || z !== ((b == 0) ? ZFLAG : 0)) begin
         errors++;
         $display("FAIL %s %0d/%0d: lat=%0d q=%0d r=%0d dbz=%0d required lat=%0d q=%0d r=%0d dbz=%0d",
                  name, a, b, lat, q, r, z, elat, ref_q(a, b), ref_r(a, b), (b == 0) ? ZFLAG : 0);
      end
      checks++;
      if (bn !== elat - 1) begin
         errors++;
         $display("FAIL %s_busy %0d/%0d: busy cycles=%0d required %0d", name, a, b, bn, elat - 1);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      check_op("basic", 13, 3);
   endtask

   task automatic test_edges;
      check_op("edge", 7, 9);
      check_op("edge", 0, 5);
      check_op("edge", 15, 15);
      check_op("edge", 15, 1);
      check_op("edge", 14, 15);
   endtask

   task automatic test_divzero;
      check_op("divzero", 11, 0);
      check_op("divzero_after", 9, 4);
      checks++;
      if (div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL divzero_clear: dbz=%0b required 0", div_by_zero);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++)
         check_op("random", int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)));
   endtask

   task automatic test_back_to_back;
      int a, b, gap;
      bit seen;
      @(negedge clk);
      dividend = W'(0); divisor = W'(1); start = 1'b1;
      for (int i = 0; i < 16 * 15; i++) begin
         a = i / 15; b = i % 15 + 1;
         gap = 0; seen = 1'b0;
         for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            gap++;
            if (done) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL b2b_timeout %0d/%0d: no done within 20 cycles", a, b);
            start = 1'b0;
            return;
         end
         if (int'(quotient) !== a / b || int'(remainder) !== a % b || gap !== W + 1) begin
            errors++;
            $display("FAIL b2b %0d/%0d: q=%0d r=%0d gap=%0d required q=%0d r=%0d gap=%0d",
                     a, b, quotient, remainder, gap, a / b, a % b, W + 1);
         end
         if (i < 16 * 15 - 1) begin
            dividend = W'((i + 1) / 15); divisor = W'((i + 1) % 15 + 1);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start;
      int lat;
      lat = -1;
      @(negedge clk);
      dividend = W'(15); divisor = W'(1); start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         start = (j == 0);
         if (j == 0) begin
            dividend = W'(6); divisor = W'(2);
         end
         if (done) begin
            lat = j + 1;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (lat !== W + 1 || quotient !== W'(15) || remainder !== W'(0)) begin
         errors++;
         $display("FAIL ignore_start: lat=%0d q=%0d r=%0d required lat=%0d q=15 r=0",
                  lat, quotient, remainder, W + 1);
      end
      repeat (8) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_extra_done: done=%0b required 0", done);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      @(negedge clk);
      dividend = W'(13); divisor = W'(3); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_busy: busy=%0b required 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL mid_run_reset: busy=%0b done=%0b q=%0d r=%0d required all 0",
                  busy, done, quotient, remainder);
      end
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_aborted: busy=%0b done=%0b required 0 0", busy, done);
         end
      end
      check_op("after_reset", 9, 4);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_edges;
      test_divzero;
      test_random;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid_run;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
